instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- PC and fetch sequencer for the 16-bit CPU. It drives the word address into the synchronous instruction ROM and presents each returned word, with its PC and a valid flag, to decode.
- Instruction ROM contract: registered output with 1-cycle latency, data(t+1) = rom[address(t)].
- ROM reset contract: the ROM ignores the address during reset and also in the first cycle after reset deasserts. In that first cycle it loads rom[0].
- Supports decode stall, redirect from branch/jump resolution, and an optional halt-word stop.

Parameters:
ADDR_WIDTH, 16, PC and ROM address width (word addressed)
INSTR_WIDTH, 16, instruction word width
HALT_WORD, 16'hFFFF, encoding that stops fetch (used only with FETCH_HALT_EN)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
imem_address  output  ADDR_WIDTH  word address to instruction ROM (combinational from state and inputs)
imem_instruction  input  INSTR_WIDTH  registered ROM output
stall  input  1  decode cannot accept; hold current instruction
redirect_en  input  1  branch/jump taken this cycle
redirect_target  input  ADDR_WIDTH  new PC when redirect_en=1
instruction  output  INSTR_WIDTH  equals imem_instruction
instruction_pc  output  ADDR_WIDTH  address of the word on instruction
instruction_valid  output  1  instruction/instruction_pc usable by decode
halted  output  1  fetch stopped on HALT_WORD (constant 0 without feature)

Behaviour:
- Registers:
  - fetch_pc: next sequential address.
  - out_pc: address whose data is on imem_instruction this cycle.
  - valid_q.
  - state: RESET, WARMUP, RUN, HALTED.
- Reset (any cycle, including mid-stall, mid-redirect or while halted):
  - state=RESET, fetch_pc=0, out_pc=0, valid_q=0, halted=0.
  - imem_address=0, instruction_valid=0.
- RESET -> WARMUP on the first cycle with reset=0.
- WARMUP:
  - The ROM is loading rom[0]. imem_address=0, instruction_valid=0.
  - Next state: fetch_pc=1, out_pc=0, valid_q=1, state=RUN.
  - stall and redirect are ignored in WARMUP.
- RUN, address select, in priority order:
  - redirect_en: imem_address=redirect_target.
  - stall: imem_address=out_pc, so the ROM re-reads the held word.
  - otherwise: imem_address=fetch_pc.
- RUN, outputs:
  - instruction=imem_instruction.
  - instruction_pc=out_pc.
  - instruction_valid = valid_q & ~redirect_en. The wrong-path word is squashed in the redirect cycle.
- RUN, next-state updates:
  - redirect_en: out_pc=redirect_target, fetch_pc=redirect_target+1, valid_q=1. Redirect wins over simultaneous stall. Zero bubble: the target word is valid the next cycle.
  - stall only: out_pc and fetch_pc hold, valid_q holds. The same word and PC are presented the next cycle.
  - neither: out_pc=fetch_pc, fetch_pc=fetch_pc+1.
- Arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF+1 = 16'h0000, with no flag.
- Latency:
  - First valid instruction (pc 0) appears 2 cycles after reset deasserts.
  - Steady state: 1 instruction per cycle.
- No combinational path from imem_instruction to imem_address except under FETCH_HALT_EN.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - In RUN with instruction_valid=1, stall=0, redirect_en=0 and imem_instruction==HALT_WORD:
    - The halt word is presented once, valid.
    - Next state: state=HALTED, halted=1, valid_q=0.
  - HALTED:
    - imem_address=out_pc, instruction_valid=0, PC frozen.
    - stall is ignored.
    - redirect_en leaves HALTED with the normal redirect update, clears halted, state=RUN.
    - reset also exits HALTED.
  - A halt word held under stall does not halt until stall drops.
- Not defined:
  - HALTED is unreachable, halted tied to 0.
  - HALT_WORD is fetched as an ordinary instruction.

Test Plan:
- Sequential fetch:
  - Stimulus: reset 3 cycles, ROM[n]=n+16'h1000.
  - Required: valid=0 for 2 cycles after reset, then (pc,instr) = (0,1000),(1,1001),(2,1002) on consecutive cycles; imem_address leads instruction_pc by 1.
- Stall:
  - Stimulus: stall=1 for 3 cycles while pc=5 is presented.
  - Required: pc=5 / instr 1005 held valid 4 cycles; imem_address=5 during stall; pc=6 on the cycle after release.
- Redirect:
  - Stimulus: redirect_en with target 16'h0040 while pc=7 is presented, stall=1 in the same cycle.
  - Required: valid=0 that cycle; next cycle pc=40 / instr 1040 valid, then pc=41.
- Wrap and reset mid-operation:
  - Stimulus: redirect to 16'hFFFE, run 3 cycles, then assert reset during a stall.
  - Required: pc sequence FFFE, FFFF, 0000; after reset, imem_address=0, valid=0, and restart at pc 0.
- Halt (FETCH_HALT_EN defined):
  - Stimulus: ROM[3]=16'hFFFF.
  - Required: pc=3 valid once; halted=1 the next cycle with valid=0 and imem_address=3; redirect to 16'h0010 resumes at pc 10 with halted=0.
- Halt (FETCH_HALT_EN undefined):
  - Stimulus: same as above.
  - Required: pc=3 then 4 and onward, halted=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// PC and fetch sequencer feeding a 1-cycle-latency synchronous instruction ROM.
// Define FETCH_HALT_EN to stop fetching when HALT_WORD is presented to decode.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = {INSTR_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instruction_pc,
  output logic                   instruction_valid,
  output logic                   halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_RESET, S_WARMUP, S_RUN, S_HALTED} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] out_pc, out_pc_next;
  logic                  valid_q, valid_next;
  logic                  halt_hit;

  // With the feature disabled this is constant 0, so HALTED can never be entered.
  assign halt_hit = HALT_EN && (imem_instruction == HALT_WORD);

  assign instruction    = imem_instruction;
  assign instruction_pc = out_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RESET;
      fetch_pc <= '0;
      out_pc   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      out_pc   <= out_pc_next;
      valid_q  <= valid_next;
    end
  end

  always_comb begin
    state_next        = state;
    fetch_pc_next     = fetch_pc;
    out_pc_next       = out_pc;
    valid_next        = valid_q;
    imem_address      = '0;
    instruction_valid = 1'b0;
    halted            = 1'b0;

    case (state)
      S_RESET: begin
        state_next = S_WARMUP;
      end
      S_WARMUP: begin
        fetch_pc_next = ADDR_WIDTH'(1);
        out_pc_next   = '0;
        valid_next    = 1'b1;
        state_next    = S_RUN;
      end
      S_RUN: begin
        instruction_valid = valid_q & ~redirect_en;
        if (redirect_en) begin
          imem_address  = redirect_target;
          out_pc_next   = redirect_target;
          fetch_pc_next = redirect_target + ADDR_WIDTH'(1);
          valid_next    = 1'b1;
        end else if (stall) begin
          // Re-read the held word so the ROM output stays on it.
          imem_address = out_pc;
        end else begin
          imem_address = fetch_pc;
          if (valid_q && halt_hit) begin
            state_next = S_HALTED;
            valid_next = 1'b0;
          end else begin
            out_pc_next   = fetch_pc;
            fetch_pc_next = fetch_pc + ADDR_WIDTH'(1);
          end
        end
      end
      S_HALTED: begin
        halted = HALT_EN;
        if (redirect_en) begin
          imem_address  = redirect_target;
          out_pc_next   = redirect_target;
          fetch_pc_next = redirect_target + ADDR_WIDTH'(1);
          valid_next    = 1'b1;
          state_next    = S_RUN;
        end else begin
          imem_address = out_pc;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

    if (reset) begin
      imem_address      = '0;
      instruction_valid = 1'b0;
      halted            = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then random stall/redirect/reset
// traffic, compared against a PC-level reference model. Honours FETCH_HALT_EN when defined.
module tb_instruction_fetch;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] imem_address;
  logic [15:0] imem_instruction = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] instruction_pc;
  logic        instruction_valid;
  logic        halted;
  logic        rom_first = 1'b0;

  int          compared = 0;
  int          mismatched = 0;

  // Reference model: cycles since reset, PC of the word being presented, halt flag.
  int          warm = 0;
  logic [15:0] m_pc = 16'h0000;
  logic        m_halted = 1'b0;

  instruction_fetch #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .HALT_WORD(HALT_WORD)) dut (
    .clk(clk),
    .reset(reset),
    .imem_address(imem_address),
    .imem_instruction(imem_instruction),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_target(redirect_target),
    .instruction(instruction),
    .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return (a == 16'd3) ? HALT_WORD : a + 16'h1000;
  endfunction

  // ROM: 1-cycle latency, loads rom[0] during reset and the first cycle after it.
  always @(posedge clk) begin
    if (reset || rom_first) imem_instruction <= rom_word(16'd0);
    else imem_instruction <= rom_word(imem_address);
    rom_first <= reset;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic re, input logic [15:0] tgt);
    logic        run;
    logic        exp_valid;
    logic [15:0] exp_addr;
    reset = rst;
    stall = st;
    redirect_en = re;
    redirect_target = tgt;
    @(negedge clk);
    run = !rst && (warm >= 2);
    if (!run) exp_addr = 16'h0000;
    else if (re) exp_addr = tgt;
    else if (m_halted || st) exp_addr = m_pc;
    else exp_addr = m_pc + 16'd1;
    exp_valid = run && !m_halted && !re;
    checkOutput("imem_address", imem_address, exp_addr);
    checkOutput("instruction_valid", instruction_valid, exp_valid);
    checkOutput("halted", halted, run && m_halted);
    if (exp_valid) begin
      checkOutput("instruction_pc", instruction_pc, m_pc);
      checkOutput("instruction", instruction, rom_word(m_pc));
    end
    @(posedge clk);
    if (rst) begin
      warm = 0;
      m_halted = 1'b0;
    end else if (warm < 2) begin
      warm++;
      m_pc = 16'h0000;
    end else if (re) begin
      m_pc = tgt;
      m_halted = 1'b0;
    end else if (m_halted || st) begin
      m_pc = m_pc;
    end else if (HALT_EN && rom_word(m_pc) == HALT_WORD) begin
      m_halted = 1'b1;
    end else begin
      m_pc = m_pc + 16'd1;
    end
    #1;
  endtask

  initial begin
    logic [15:0] tgt;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0005);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0007);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0: tgt = 16'($urandom_range(0, 15));
        1: tgt = 16'hFFFC + 16'($urandom_range(0, 3));
        default: tgt = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
